// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the ID stage and the write-back/register-file block.
// Latency: none; this file only groups the signals.
// Backpressure: none; the pipeline stalls by sending bubbles (type 0, wwreg=0).
interface wb_regfile_if #(
  parameter int CNT_W = 16
);
  // MEM/WB side
  logic             wwreg;
  logic             wm2reg;
  logic [31:0]      wdata_out;
  logic [31:0]      waluout;
  logic [4:0]       wrdrt;
  logic [3:0]       WB_ins_type;
  logic [3:0]       WB_ins_number;
  // ID-stage read ports
  logic [4:0]       rna;
  logic [4:0]       rnb;
  logic [31:0]      qa;
  logic [31:0]      qb;
  // forwarding and debug/display
  logic [31:0]      wb_result;
  logic [CNT_W-1:0] retired;
  logic [3:0]       last_ins_type;
  logic [3:0]       last_ins_number;
  logic [4:0]       dbg_addr;
  logic [31:0]      dbg_data;

  // Pipeline side: drives the stage inputs and consumes the results.
  modport master (
    output wwreg, wm2reg, wdata_out, waluout, wrdrt, WB_ins_type, WB_ins_number,
           rna, rnb, dbg_addr,
    input  qa, qb, wb_result, retired, last_ins_type, last_ins_number, dbg_data
  );

  // Register-file side.
  modport slave (
    input  wwreg, wm2reg, wdata_out, waluout, wrdrt, WB_ins_type, WB_ins_number,
           rna, rnb, dbg_addr,
    output qa, qb, wb_result, retired, last_ins_type, last_ins_number, dbg_data
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select, 32x32 register file (r0 = 0), retirement counter and last-retired tags.
// Latency: writes and retirement take effect 1 edge later; WB_BYPASS_EN makes qa/qb write-through.
// Backpressure: none; the stage accepts one instruction per cycle and bubbles (type 0) are ignored.
module wb_regfile #(
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           clrn,
  wb_regfile_if.slave   bus
);

  logic [31:0]      regs_q [NREGS];
  logic [31:0]      regs_d [NREGS];
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [3:0]       last_type_q, last_type_d;
  logic [3:0]       last_num_q, last_num_d;

  logic [31:0]      wb_result;
  logic             wr_en;
  logic             retire;

  // Write-back value selection is purely combinational so EX/ID can forward it.
  assign wb_result = bus.wm2reg ? bus.wdata_out : bus.waluout;
  // r0 is hardwired; a write aimed at it is dropped here, so regs_q[0] never leaves zero.
  assign wr_en     = bus.wwreg && (bus.wrdrt != 5'd0);
  assign retire    = (bus.WB_ins_type != 4'd0);

  // Next-state: commit the write-back value and count non-bubble retirements.
  always_comb begin
    regs_d      = regs_q;
    retired_d   = retired_q;
    last_type_d = last_type_q;
    last_num_d  = last_num_q;
    if (wr_en) begin
      regs_d[bus.wrdrt] = wb_result;
    end
    if (retire) begin
      retired_d   = retired_q + CNT_W'(1);
      last_type_d = bus.WB_ins_type;
      last_num_d  = bus.WB_ins_number;
    end
  end

  // State registers; reset clears the array and bookkeeping immediately.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      regs_q      <= '{default: '0};
      retired_q   <= '0;
      last_type_q <= '0;
      last_num_q  <= '0;
    end else begin
      regs_q      <= regs_d;
      retired_q   <= retired_d;
      last_type_q <= last_type_d;
      last_num_q  <= last_num_d;
    end
  end

  // Read ports; the optional write-through covers the WB->ID hazard for qa/qb only.
  always_comb begin
    bus.qa       = (bus.rna == 5'd0) ? 32'd0 : regs_q[bus.rna];
    bus.qb       = (bus.rnb == 5'd0) ? 32'd0 : regs_q[bus.rnb];
    bus.dbg_data = (bus.dbg_addr == 5'd0) ? 32'd0 : regs_q[bus.dbg_addr];
`ifdef WB_BYPASS_EN
    if (wr_en && (bus.rna == bus.wrdrt)) begin
      bus.qa = wb_result;
    end
    if (wr_en && (bus.rnb == bus.wrdrt)) begin
      bus.qb = wb_result;
    end
`endif
  end

  assign bus.wb_result       = wb_result;
  assign bus.retired         = retired_q;
  assign bus.last_ins_type   = last_type_q;
  assign bus.last_ins_number = last_num_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a 4-bit retirement counter so wrap is reachable.
// Latency: checks sample 1 time unit after the rising edge, or 1 unit after driving inputs.
// Backpressure: not applicable; every cycle presents either an instruction or a bubble.
module tb_wb_regfile;

  logic clk;
  logic clrn;
  int   n_vec;
  int   n_bad;
  logic [31:0] exp_same;

  wb_regfile_if #(.CNT_W(4)) bus ();

  wb_regfile #(.NREGS(32), .CNT_W(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] dout,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic [3:0] typ, input logic [3:0] num);
    bus.wwreg         = we;
    bus.wm2reg        = m2r;
    bus.wdata_out     = dout;
    bus.waluout       = alu;
    bus.wrdrt         = rd;
    bus.WB_ins_type   = typ;
    bus.WB_ins_number = num;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0, 4'd0);
  endtask

  task automatic rd_addr(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    bus.rna      = a;
    bus.rnb      = b;
    bus.dbg_addr = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
`ifdef WB_BYPASS_EN
    exp_same = 32'h0000_A5A5;
`else
    exp_same = 32'h0000_0000;
`endif
    clrn = 1'b0;
    bubble();
    rd_addr(5'd5, 5'd6, 5'd7);
    #3;
    chk("rst_qa", bus.qa, 32'd0);
    chk("rst_qb", bus.qb, 32'd0);
    chk("rst_dbg", bus.dbg_data, 32'd0);
    chk("rst_retired", 32'(bus.retired), 32'd0);
    chk("rst_type", 32'(bus.last_ins_type), 32'd0);
    chk("rst_num", 32'(bus.last_ins_number), 32'd0);
    #9;
    clrn = 1'b1;
    step();

    // ALU result to r5
    drive(1'b1, 1'b0, 32'h0000_DEAD, 32'h0000_1234, 5'd5, 4'd1, 4'd1);
    #1;
    chk("sel_alu", bus.wb_result, 32'h0000_1234);
    step();
    chk("ret_after1", 32'(bus.retired), 32'd1);
    // load data to r6
    drive(1'b1, 1'b1, 32'h0000_DEAD, 32'h0000_1234, 5'd6, 4'd2, 4'd2);
    #1;
    chk("sel_load", bus.wb_result, 32'h0000_DEAD);
    step();
    bubble();
    #1;
    chk("rd_r5", bus.qa, 32'h0000_1234);
    chk("rd_r6", bus.qb, 32'h0000_DEAD);
    rd_addr(5'd5, 5'd6, 5'd6);
    #1;
    chk("dbg_r6", bus.dbg_data, 32'h0000_DEAD);
    chk("ret_after2", 32'(bus.retired), 32'd2);

    // write attempt to r0 still retires
    drive(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 4'd5, 4'd3);
    step();
    bubble();
    rd_addr(5'd0, 5'd0, 5'd0);
    #1;
    chk("r0_qa", bus.qa, 32'd0);
    chk("r0_dbg", bus.dbg_data, 32'd0);
    chk("r0_retired", 32'(bus.retired), 32'd3);
    chk("r0_type", 32'(bus.last_ins_type), 32'd5);
    chk("r0_num", 32'(bus.last_ins_number), 32'd3);

    // same-cycle write and read of r7
    rd_addr(5'd7, 5'd7, 5'd7);
    drive(1'b1, 1'b0, 32'd0, 32'h0000_A5A5, 5'd7, 4'd1, 4'd4);
    #1;
    chk("same_qa", bus.qa, exp_same);
    chk("same_qb", bus.qb, exp_same);
    chk("same_dbg", bus.dbg_data, 32'd0);
    step();
    bubble();
    #1;
    chk("next_qa", bus.qa, 32'h0000_A5A5);
    chk("next_dbg", bus.dbg_data, 32'h0000_A5A5);

    // retire without writing (store-like)
    drive(1'b0, 1'b0, 32'd0, 32'h0000_1111, 5'd8, 4'd6, 4'd9);
    rd_addr(5'd8, 5'd8, 5'd8);
    #1;
    chk("nowr_same_qa", bus.qa, 32'd0);
    step();
    bubble();
    #1;
    chk("nowr_qa", bus.qa, 32'd0);
    chk("nowr_retired", 32'(bus.retired), 32'd5);
    chk("nowr_type", 32'(bus.last_ins_type), 32'd6);

    // type1 #1, bubble, type3 #2
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 4'd1, 4'd1);
    step();
    bubble();
    step();
    chk("bub_retired", 32'(bus.retired), 32'd6);
    chk("bub_type", 32'(bus.last_ins_type), 32'd1);
    chk("bub_num", 32'(bus.last_ins_number), 32'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 4'd3, 4'd2);
    step();
    bubble();
    chk("seq_retired", 32'(bus.retired), 32'd7);
    chk("seq_type", 32'(bus.last_ins_type), 32'd3);
    chk("seq_num", 32'(bus.last_ins_number), 32'd2);

    // asynchronous reset mid-cycle after writes
    rd_addr(5'd5, 5'd6, 5'd7);
    #1;
    clrn = 1'b0;
    #1;
    chk("arst_qa", bus.qa, 32'd0);
    chk("arst_qb", bus.qb, 32'd0);
    chk("arst_dbg", bus.dbg_data, 32'd0);
    chk("arst_retired", 32'(bus.retired), 32'd0);
    chk("arst_type", 32'(bus.last_ins_type), 32'd0);
    chk("arst_num", 32'(bus.last_ins_number), 32'd0);
    // writes and retirement ignored while held in reset
    drive(1'b1, 1'b0, 32'd0, 32'h0000_0077, 5'd5, 4'd1, 4'd1);
    step();
    chk("inrst_qa", bus.qa, 32'd0);
    chk("inrst_retired", 32'(bus.retired), 32'd0);
    #2;
    clrn = 1'b1;
    bubble();

    // 17 retirements on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 4'((i % 15) + 1), 4'(i));
      step();
      if (i == 14) chk("wrap_15", 32'(bus.retired), 32'd15);
      if (i == 15) chk("wrap_0", 32'(bus.retired), 32'd0);
    end
    bubble();
    chk("wrap_1", 32'(bus.retired), 32'd1);
    chk("wrap_type", 32'(bus.last_ins_type), 32'd2);
    chk("wrap_num", 32'(bus.last_ins_number), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage pipeline. It consumes the MEM/WB pipeline register outputs and selects the write-back value (load data or ALU result). It commits that value to a 32×32 register file and serves the two combinational read ports used by the ID stage. It also keeps retirement bookkeeping (retired-instruction counter, last retired instruction tag) for the lab display/debug path.

## Interface
Parameters:
- `NREGS`, 32: register count; register 0 is hardwired to zero.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `wwreg`  in  1  register-write enable from MEM/WB.
- `wm2reg`  in  1  1 = write load data, 0 = write ALU result.
- `wdata_out`  in  32  load data from MEM/WB.
- `waluout`  in  32  ALU result from MEM/WB.
- `wrdrt`  in  5  destination register number.
- `WB_ins_type`  in  4  instruction type tag; 4'd0 = bubble/NOP.
- `WB_ins_number`  in  4  instruction sequence tag.
- `rna`, `rnb`  in  5  ID-stage read addresses.
- `qa`, `qb`  out  32  ID-stage read data.
- `wb_result`  out  32  selected write-back value, for EX/ID forwarding.
- `retired`  out  CNT_W  count of non-bubble instructions retired.
- `last_ins_type`  out  4  type tag of the most recently retired non-bubble instruction.
- `last_ins_number`  out  4  number tag of the same instruction.
- `dbg_addr`  in  5  debug read address.
- `dbg_data`  out  32  debug read data, combinational.

## Operation
- `wb_result = wm2reg ? wdata_out : waluout`; combinational, always driven, independent of `wwreg`.
- Commit: at a rising `clk` edge with `wwreg==1` and `wrdrt!=0`, write `regs[wrdrt] <= wb_result`. A write with `wrdrt==0` is discarded.
- Reads: `qa = regs[rna]` and `qb = regs[rnb]`; address 0 always returns 0. `dbg_data` follows the same rule.
- Retirement: at a rising edge with `WB_ins_type != 0`:
  - `retired` increments by 1, wrapping modulo 2^CNT_W;
  - `last_ins_type`/`last_ins_number` load the current tags.
  - Bubbles (`WB_ins_type == 0`) change neither.
  - Retirement is independent of `wwreg`: stores and branches retire without writing.
- No stall input. A stall reaches this stage only as a bubble (type 0, `wwreg=0`).

## Timing
- Register write latency: 1 edge. A value presented in cycle N is visible on the read ports in cycle N+1 without the bypass; see Configuration for same-cycle visibility.
- Reset (`clrn` low, asynchronous, effective immediately mid-cycle): all registers 0; `retired=0`; `last_ins_type=0`; `last_ins_number=0`. Consequently `qa`, `qb` and `dbg_data` read 0.
- While `clrn` is low, write enables are ignored. Release of `clrn` takes effect at the next rising edge.
- Simultaneous read and write of the same register in one cycle: the result is governed by the macro below.
- Counter wrap: from 2^CNT_W−1, `retired` goes to 0 on the next retirement, with no flag.

## Configuration
- `WB_BYPASS_EN` defined: internal write-through. When `wwreg && wrdrt!=0 && rna==wrdrt`, `qa = wb_result` in the same cycle; the same rule applies to `qb`/`rnb`. `dbg_data` is never bypassed. This closes the WB→ID hazard without a third forwarding path.
- `WB_BYPASS_EN` undefined: read ports return array contents only. The hazard unit must stall one extra cycle for a WB→ID dependency.

## Test plan
- Reset: pulse `clrn` low mid-cycle after writes → all `qa`/`qb` reads 0, `retired=0`, tags 0, asynchronously before the next edge.
- ALU vs load select: `wwreg=1`, `wrdrt=5`, `wm2reg=0`, `waluout=32'h1234`, `wdata_out=32'hDEAD`, then read `rna=5` → `32'h1234`. Repeat with `wm2reg=1` to r6 → `32'hDEAD`.
- r0 protection: write `32'hFFFF_FFFF` to r0 with `wwreg=1` → `qa` with `rna=0` stays 0, `retired` still increments when type≠0.
- Same-cycle read/write of r7 = `32'hA5A5`, previous content 0 → `qa=32'hA5A5` in that cycle with `WB_BYPASS_EN` defined, `qa=0` without it; both give `32'hA5A5` next cycle.
- Retirement: 3 instructions (type 1,#1; type 0 bubble; type 3,#2) → `retired=2`, `last_ins_type=3`, `last_ins_number=2`.
- Wrap: with `CNT_W=4`, retire 17 non-bubble instructions → `retired=1`.
